// File: rtl/rename_freelist.sv
// Physical integer register free list for rename: FIFO of free indices with a
// speculative head (allocation), an architectural head (commit) and a tail (release).
module rename_freelist #(
  parameter int NUM_PHYREG   = 64,
  parameter int NUM_LOGREG   = 32,
  parameter int RENAME_WIDTH = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int FL_DEPTH    = NUM_PHYREG - NUM_LOGREG,
  localparam int IW          = $clog2(NUM_PHYREG),
  localparam int CNTW        = $clog2(FL_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RENAME_WIDTH-1:0] i_alloc_req,
  input  logic                    i_alloc_fire,
  output logic                    o_can_alloc,
  output logic [IW-1:0]           o_alloc_iprd [RENAME_WIDTH],
  input  logic [COMMIT_WIDTH-1:0] i_free_vld,
  input  logic [IW-1:0]           i_free_iprd [COMMIT_WIDTH],
  input  logic                    i_squash_vld,
  output logic [CNTW-1:0]         o_free_count,
  output logic                    o_recovering
);

  localparam int LW = $clog2(FL_DEPTH);
  localparam int PW = LW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {NORMAL, RECOVER} state_t;

  logic [IW-1:0] fl [FL_DEPTH];
  ptr_t          spec_head;
  ptr_t          arch_head;
  ptr_t          tail;
  state_t        state;

  ptr_t          req_pre  [RENAME_WIDTH+1];
  ptr_t          free_pre [COMMIT_WIDTH+1];
  ptr_t          alloc_ptr [RENAME_WIDTH];
  ptr_t          free_ptr  [COMMIT_WIDTH];
  ptr_t          req_cnt;
  ptr_t          free_cnt;
  ptr_t          count;
  logic          do_alloc;

  // Advance a pointer by n; low bits wrap mod FL_DEPTH and the wrap bit toggles.
  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t n);
    logic [LW+1:0] s;
    s = {2'b00, p[LW-1:0]} + {1'b0, n};
    if (s >= (LW+2)'(FL_DEPTH)) ptr_add = {~p[LW], LW'(s - (LW+2)'(FL_DEPTH))};
    else                        ptr_add = {p[LW], s[LW-1:0]};
  endfunction

  function automatic ptr_t ptr_diff(input ptr_t t, input ptr_t h);
    logic [LW+1:0] d;
    if (t[LW] == h[LW]) d = {2'b00, t[LW-1:0]} - {2'b00, h[LW-1:0]};
    else                d = (LW+2)'(FL_DEPTH) + {2'b00, t[LW-1:0]} - {2'b00, h[LW-1:0]};
    ptr_diff = d[LW:0];
  endfunction

  // Handshake: i_alloc_req is the request, o_can_alloc the ready; indices are
  // consumed only on an edge where i_alloc_fire and o_can_alloc are both high
  // and no squash is present. Releases (i_free_vld) are always accepted.
  always_comb begin
    req_pre[0] = '0;
    for (int k = 0; k < RENAME_WIDTH; k++)
      req_pre[k+1] = req_pre[k] + {{LW{1'b0}}, i_alloc_req[k]};
    free_pre[0] = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++)
      free_pre[j+1] = free_pre[j] + {{LW{1'b0}}, i_free_vld[j]};
    req_cnt  = req_pre[RENAME_WIDTH];
    free_cnt = free_pre[COMMIT_WIDTH];
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      alloc_ptr[k]    = ptr_add(spec_head, req_pre[k]);
      o_alloc_iprd[k] = fl[alloc_ptr[k][LW-1:0]];
    end
    for (int j = 0; j < COMMIT_WIDTH; j++)
      free_ptr[j] = ptr_add(tail, free_pre[j]);
    count        = ptr_diff(tail, spec_head);
    o_free_count = CNTW'(count);
    o_can_alloc  = (state == NORMAL) && (count >= req_cnt);
    o_recovering = (state == RECOVER);
    do_alloc     = i_alloc_fire && o_can_alloc && !i_squash_vld;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= IW'(NUM_LOGREG + i);
      spec_head <= '0;
      arch_head <= '0;
      tail      <= {1'b1, {LW{1'b0}}};
      state     <= NORMAL;
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++)
        if (i_free_vld[j]) fl[free_ptr[j][LW-1:0]] <= i_free_iprd[j];
      tail      <= ptr_add(tail, free_cnt);
      arch_head <= ptr_add(arch_head, free_cnt);
      // Squash rewinds to the committed point, counting this cycle's commits.
      if (i_squash_vld)  spec_head <= ptr_add(arch_head, free_cnt);
      else if (do_alloc) spec_head <= ptr_add(spec_head, req_cnt);
      case (state)
        NORMAL:  state <= i_squash_vld ? RECOVER : NORMAL;
        RECOVER: state <= i_squash_vld ? RECOVER : NORMAL;
        default: state <= NORMAL;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(i_alloc_fire && !o_can_alloc))
    else $error("alloc fire while o_can_alloc is low");

  assert property (@(posedge clk) disable iff (!rst) free_cnt <= ptr_t'(FL_DEPTH) - count)
    else $error("free list overflow");

endmodule
